matx_host_if: RTL

Host-side initiator for the 4x4 nibble matrix-vector multiplier. It accepts a byte stream carrying one 4x4 matrix of 4-bit elements and one 4-element 4-bit vector, drives the multiplier's row, vector and start inputs, and waits for done. It then captures the 32-bit result and returns it as a 4-byte ready/valid stream. It also owns the multiplier's reset, because the multiplier's done flag is sticky and only clears on reset.

---
 rtl/matx_pkg.sv | 26 ++
 rtl/matx_if.sv | 31 +++
 rtl/matx_result_ser.sv | 39 +++
 rtl/matx_host_if.sv | 120 ++++++++++++
 4 files changed

// File: rtl/matx_pkg.sv
// Shared types and constants for the matrix-vector host initiator.
package matx_pkg;

    typedef enum logic [2:0] {LOAD, CLR, START, WAIT, SEND} state_t;

    localparam int IN_BYTES           = 10;
    localparam int OUT_BYTES          = 4;
    localparam int MP_LATENCY         = 17;
    localparam int TIMEOUT_CYCLES_DEF = 32;

    localparam logic [3:0] IN_LAST  = 4'(IN_BYTES - 1);
    localparam logic [1:0] OUT_LAST = 2'(OUT_BYTES - 1);

    // Result bytes leave most-significant first: index 0 is b0 in [31:24].
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/matx_if.sv
// Byte streams in/out of the host plus the multiplier operand/control bus.
interface matx_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        err;
    logic        mp_nrst;
    logic        mp_start;
    logic [15:0] mp_a1_row;
    logic [15:0] mp_a2_row;
    logic [15:0] mp_a3_row;
    logic [15:0] mp_a4_row;
    logic [15:0] mp_x_col;
    logic [31:0] mp_b_col;
    logic        mp_done;

    modport master (
        input  in_valid, in_data, out_ready, mp_b_col, mp_done,
        output in_ready, out_valid, out_data, err, mp_nrst, mp_start,
               mp_a1_row, mp_a2_row, mp_a3_row, mp_a4_row, mp_x_col
    );

    modport slave (
        output in_valid, in_data, out_ready, mp_b_col, mp_done,
        input  in_ready, out_valid, out_data, err, mp_nrst, mp_start,
               mp_a1_row, mp_a2_row, mp_a3_row, mp_a4_row, mp_x_col
    );
endinterface

// File: rtl/matx_result_ser.sv
// Holds the 32-bit multiplier result and streams it out as 4 bytes, b0 first.
// Latency: out_vld the cycle after load. Backpressure: byte held stable until out_rdy.
module matx_result_ser
    import matx_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        load,
    input  logic [31:0] load_dat,
    input  logic        out_rdy,
    output logic        out_vld,
    output logic [7:0]  out_dat,
    output logic        last_acc
);

    logic [31:0] res;
    logic [1:0]  idx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            res     <= '0;
            idx     <= '0;
            out_vld <= 1'b0;
        end else if (load) begin
            res     <= load_dat;
            idx     <= '0;
            out_vld <= 1'b1;
        end else if (out_vld && out_rdy) begin
            idx <= idx + 2'd1;
            if (idx == OUT_LAST) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign out_dat  = pick_byte(res, idx);
    assign last_acc = out_vld && out_rdy && (idx == OUT_LAST);

endmodule

// File: rtl/matx_host_if.sv
// Host initiator for the 4x4 nibble multiplier: 10 bytes in, clear/start/wait, 4 bytes out. MATX_HOST_TIMEOUT_EN adds a WAIT watchdog.
// Latency: first result byte 20 cycles after the last input byte is accepted.
// Backpressure: in_ready only in LOAD; result bytes wait on out_ready.
module matx_host_if
    import matx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   nrst,
    matx_if.master bus
);

    state_t           state;
    logic [3:0]       in_cnt;
    logic [4:0][15:0] ops;
    logic [2:0]       op_idx;
    logic             in_acc;
    logic             res_load;
    logic             ser_last;
    logic             timeout;
    logic             mp_nrst_q;
    logic             mp_start_q;

    assign op_idx   = in_cnt[3:1];
    assign in_acc   = bus.in_valid && (state == LOAD);
    assign res_load = (state == WAIT) && bus.mp_done;

    // The multiplier's done is sticky, so every job is preceded by a one-cycle reset pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= LOAD;
            in_cnt     <= '0;
            ops        <= '0;
            mp_nrst_q  <= 1'b0;
            mp_start_q <= 1'b0;
        end else begin
            mp_nrst_q  <= 1'b1;
            mp_start_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        if (in_cnt[0]) ops[op_idx][7:0]  <= bus.in_data;
                        else           ops[op_idx][15:8] <= bus.in_data;
                        if (in_cnt == IN_LAST) begin
                            in_cnt    <= '0;
                            state     <= CLR;
                            mp_nrst_q <= 1'b0;
                        end else begin
                            in_cnt <= in_cnt + 4'd1;
                        end
                    end
                end
                CLR: begin
                    state      <= START;
                    mp_start_q <= 1'b1;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (bus.mp_done)  state <= SEND;
                    else if (timeout) state <= LOAD;
                end
                SEND: begin
                    if (ser_last) state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef MATX_HOST_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    logic [WCW-1:0] wait_cnt;
    logic           err_q;

    assign timeout = (state == WAIT) && !bus.mp_done && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (timeout)     err_q <= 1'b1;
            else if (in_acc) err_q <= 1'b0;
        end
    end

    assign bus.err = err_q;
`else
    // No watchdog: WAIT holds until done arrives.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign bus.err            = 1'b0;
`endif

    matx_result_ser u_ser (
        .clk      (clk),
        .nrst     (nrst),
        .load     (res_load),
        .load_dat (bus.mp_b_col),
        .out_rdy  (bus.out_ready),
        .out_vld  (bus.out_valid),
        .out_dat  (bus.out_data),
        .last_acc (ser_last)
    );

    assign bus.in_ready  = (state == LOAD);
    assign bus.mp_nrst   = mp_nrst_q;
    assign bus.mp_start  = mp_start_q;
    assign bus.mp_a1_row = ops[0];
    assign bus.mp_a2_row = ops[1];
    assign bus.mp_a3_row = ops[2];
    assign bus.mp_a4_row = ops[3];
    assign bus.mp_x_col  = ops[4];

endmodule
